// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D memory port arbiter.
// The state encoding, the grant encoding and the wait-counter width are all defined here.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;
    localparam int   WAIT_W   = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker: chooses between fetch and data requests.
// Zero latency. Ties go to D when priority is set, otherwise to the port that did not win last time.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int DATA_PRIORITY = 1
) (
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant,
    output logic valid
);
    always_comb begin
        valid = if_req | d_req;
        grant = GRANT_IF;
        if (if_req && d_req) begin
            grant = (DATA_PRIORITY != 0) ? GRANT_D : ~last_grant;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store via req/ack.
// The latency from req to ack is WAIT_CYCLES+2. Requests stay pending until IDLE samples them, and the memory-side outputs decode from registers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int WAIT_CYCLES   = 0,
    parameter int DATA_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_t            state;
    logic              grant_q;
    logic              last_grant;
    logic              we_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_grant;
    logic              pick_valid;
    logic              in_access;

    mem_arb_pick #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= GRANT_IF;
            last_grant <= GRANT_IF;
            we_q       <= 1'b0;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick_grant;
                        last_grant <= pick_grant;
                        we_q       <= (pick_grant == GRANT_D) ? d_we : 1'b0;
                        addr_q     <= (pick_grant == GRANT_D) ? d_addr : if_addr;
                        wdata_q    <= (pick_grant == GRANT_D) ? d_wdata : '0;
                        wait_cnt   <= WAIT_INIT;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        // Stores complete without touching d_rdata.
                        if (grant_q == GRANT_IF) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            if (!we_q) d_rdata <= mem_rdata;
                            d_ack <= 1'b1;
                        end
                        state <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_access = (state == ACCESS);
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign mem_read  = in_access && !we_q;
    // The write strobe is limited to the last ACCESS cycle, so the memory sees exactly one write edge.
    assign mem_write = in_access && we_q && (wait_cnt == '0);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiter instances (W2/DP1, W0/DP1, W0/DP0, W3/DP1), each with its own memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst = 4'hF;
    logic [3:0]  if_req, d_req, d_we, if_ack, d_ack, mem_read, mem_write, busy;
    logic [31:0] if_addr [4];
    logic [31:0] d_addr [4];
    logic [31:0] d_wdata [4];
    logic [31:0] if_rdata [4];
    logic [31:0] d_rdata [4];
    logic [31:0] mem_addr [4];
    logic [31:0] mem_wdata [4];
    logic [31:0] mem_rdata [4];

    logic [31:0] mem [4][64];
    logic        mem_init = 1'b1;
    int          wr_cnt [4];
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_init) begin
                for (int j = 0; j < 64; j++)
                    mem[k][j] <= (j == 0) ? 32'h20040005 : (j == 1) ? 32'h00001026 : 32'h0;
            end else if (mem_write[k]) begin
                mem[k][mem_addr[k][7:2]] <= mem_wdata[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32),
            .WAIT_CYCLES(g == 0 ? 2 : (g == 3 ? 3 : 0)),
            .DATA_PRIORITY(g == 2 ? 0 : 1)
        ) u_dut (
            .clk(clk), .reset(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g][7:2]];
    end

    // Drives one request, waits (bounded) for its ack, and reports latency and read-strobe activity.
    task automatic access(input int k, input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output int rd_cyc, output bit addr_ok);
        bit got;
        @(negedge clk);
        if (port) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        lat = 0; rd_cyc = 0; addr_ok = 1'b1; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_read[k]) begin
                rd_cyc++;
                if (mem_addr[k] !== addr) addr_ok = 1'b0;
            end
            got = port ? (d_ack[k] === 1'b1) : (if_ack[k] === 1'b1);
        end
        rdata = port ? d_rdata[k] : if_rdata[k];
        if (port) begin d_req[k] = 1'b0; d_we[k] = 1'b0; end
        else if_req[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 4'hF; mem_init = 1'b1;
        if_req = '0; d_req = '0; d_we = '0;
        for (int k = 0; k < 4; k++) begin
            if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy[k], if_ack[k], d_ack[k], mem_read[k], mem_write[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 00000", k,
                         {busy[k], if_ack[k], d_ack[k], mem_read[k], mem_write[k]});
            end
            checks++;
            if (mem_addr[k] !== 32'h0 || if_rdata[k] !== 32'h0 || d_rdata[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: addr=%h if_rdata=%h d_rdata=%h expected all 0",
                         k, mem_addr[k], if_rdata[k], d_rdata[k]);
            end
        end
        mem_init = 1'b0;
        rst = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int w0, lat, rc; logic [31:0] rd; bit ok, seen;
        @(negedge clk);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h80; d_wdata[0] = 32'h11111111;
        w0 = wr_cnt[0];
        repeat (2) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || mem_write[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b mem_write=%b expected busy=1 mem_write=0", busy[0], mem_write[0]);
        end
        rst[0] = 1'b1;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: busy=%b rd=%b wr=%b expected 0 0 0", busy[0], mem_read[0], mem_write[0]);
        end
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (d_ack[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_noack: got d_ack seen=%b expected 0", seen);
        end
        checks++;
        if (wr_cnt[0] !== w0) begin
            errors++;
            $display("FAIL midrst_nowrite: got %0d writes expected 0", wr_cnt[0] - w0);
        end
        access(0, 1'b1, 1'b0, 32'h80, 32'h0, lat, rd, rc, ok);
        checks++;
        if (rd !== 32'h0 || lat !== 4) begin
            errors++;
            $display("FAIL midrst_load: got rdata=%h lat=%0d expected 00000000 lat=4", rd, lat);
        end
    endtask

    task automatic test_fetch();
        int lat, rc; logic [31:0] rd; bit ok;
        access(1, 1'b0, 1'b0, 32'h0, 32'h0, lat, rd, rc, ok);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL fetch_lat: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'h20040005 || rc !== 1) begin
            errors++; $display("FAIL fetch_data: got %h rd_cyc=%0d expected 20040005 rd_cyc=1", rd, rc);
        end
    endtask

    task automatic test_store_load();
        int w0, lat, rc; logic [31:0] rd; bit ok;
        w0 = wr_cnt[1];
        access(1, 1'b1, 1'b1, 32'h80, 32'hDEADBEEF, lat, rd, rc, ok);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || rc !== 0) begin
            errors++;
            $display("FAIL store: got lat=%0d d_rdata=%h rd_cyc=%0d expected lat=2 d_rdata=0 rd_cyc=0", lat, rd, rc);
        end
        access(1, 1'b1, 1'b0, 32'h80, 32'h0, lat, rd, rc, ok);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 2) begin
            errors++; $display("FAIL load: got %h lat=%0d expected deadbeef lat=2", rd, lat);
        end
        checks++;
        if (wr_cnt[1] - w0 !== 1) begin
            errors++; $display("FAIL write_count: got %0d expected 1", wr_cnt[1] - w0);
        end
    endtask

    task automatic test_round_robin();
        int cyc, n;
        bit          port_seen [4];
        int          t_seen [4];
        logic [31:0] r_seen [4];
        @(negedge clk);
        if_req[2] = 1'b1; if_addr[2] = 32'h0;
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h4;
        cyc = 0; n = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (d_ack[2] === 1'b1 || if_ack[2] === 1'b1) begin
                port_seen[n] = d_ack[2];
                t_seen[n]    = cyc;
                r_seen[n]    = d_ack[2] ? d_rdata[2] : if_rdata[2];
                n++;
            end
        end
        if_req[2] = 1'b0; d_req[2] = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL rr_count: got %0d acks expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (port_seen[i] !== ((i % 2) == 0) ||
                r_seen[i] !== (((i % 2) == 0) ? 32'h00001026 : 32'h20040005) ||
                t_seen[i] !== 2 + 3 * i) begin
                errors++;
                $display("FAIL rr_ack%0d: got port=%0d t=%0d data=%h expected port=%0d t=%0d data=%h",
                         i, port_seen[i], t_seen[i], r_seen[i], (i % 2) == 0, 2 + 3 * i,
                         ((i % 2) == 0) ? 32'h00001026 : 32'h20040005);
            end
        end
    endtask

    task automatic test_priority();
        int cyc, nd, t_d, t_if; bit early;
        @(negedge clk);
        if_req[1] = 1'b1; if_addr[1] = 32'h0;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h4;
        cyc = 0; nd = 0; t_d = 0; t_if = -1; early = 1'b0;
        while (t_if < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (if_ack[1] === 1'b1) begin
                t_if = cyc;
                if (nd < 4) early = 1'b1;
            end
            if (d_ack[1] === 1'b1) begin
                nd++;
                if (nd == 4) begin d_req[1] = 1'b0; t_d = cyc; end
            end
        end
        if_req[1] = 1'b0; d_req[1] = 1'b0;
        checks++;
        if (early !== 1'b0 || nd !== 4) begin
            errors++; $display("FAIL prio_starve: got early_if=%b d_acks=%0d expected 0 and 4", early, nd);
        end
        checks++;
        if (t_if - t_d !== 3) begin
            errors++; $display("FAIL prio_if_gap: got %0d expected 3", t_if - t_d);
        end
        checks++;
        if (if_rdata[1] !== 32'h20040005) begin
            errors++; $display("FAIL prio_if_data: got %h expected 20040005", if_rdata[1]);
        end
    endtask

    task automatic test_wait_states();
        int lat, rc; logic [31:0] rd; bit ok;
        access(3, 1'b0, 1'b0, 32'h4, 32'h0, lat, rd, rc, ok);
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL wait_lat: got %0d expected 5", lat);
        end
        checks++;
        if (rc !== 4 || ok !== 1'b1) begin
            errors++; $display("FAIL wait_strobe: got rd_cyc=%0d addr_ok=%b expected 4 and 1", rc, ok);
        end
        checks++;
        if (rd !== 32'h00001026) begin
            errors++; $display("FAIL wait_data: got %h expected 00001026", rd);
        end
        checks++;
        if (mem_addr[3] !== 32'h0 || mem_read[3] !== 1'b0) begin
            errors++; $display("FAIL ack_idle_bus: got addr=%h rd=%b expected 0 0", mem_addr[3], mem_read[3]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_fetch();
        test_store_load();
        test_round_robin();
        test_priority();
        test_wait_states();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
